multi_threshold_timer: RTL and testbench
========================================

Name: multi_threshold_timer

Overview:
- Single free-running tick counter with NUM_THRESH compare thresholds, each with its own expired level and one-cycle hit pulse.
- Replaces one timer instance per interval (dash, illegal symbol, char gap, word gap) in morse_decoder with one shared counter.
- Adds a built-in prescaler, a hold (pause) input, saturation at the largest threshold, and a count readout.

Parameters:
- NUM_THRESH, 4, number of compare thresholds.
- THRESH, TIMER_THRESH_C (package), packed array [NUM_THRESH] of CNT_WIDTH-bit tick counts, strictly ascending, each >= 1.
- PRESCALE, 1, clock cycles per counter tick (>= 1).
- CNT_WIDTH, $clog2(THRESH[NUM_THRESH-1]+1), counter width.

Ports:
- clk  in  1  system clock.
- resetn  in  1  asynchronous active-low reset.
- clear_i  in  1  synchronous clear/restart; highest functional priority.
- hold_i  in  1  freeze counter and prescaler without clearing.
- en_i  in  1  tick enable; prescaler advances only when high.
- count_o  out  CNT_WIDTH  current tick count.
- expired_o  out  NUM_THRESH  level: bit k = (count_o >= THRESH[k]).
- hit_o  out  NUM_THRESH  one-cycle pulse when count_o first reaches THRESH[k].
- sat_o  out  1  count_o == THRESH[NUM_THRESH-1].

Behaviour:
- Reset (resetn low, async): pre_q=0, count_q=0, hit_q=0. All outputs are 0 immediately and stay 0 until the first edge after release.
- Priority per edge: clear_i > hold_i > en_i.
- clear_i=1: pre_q<=0, count_q<=0, hit_q<=0. Outputs are 0 from the next cycle. Holding clear_i high keeps the timer idle.
- hold_i=1 (clear_i=0): pre_q, count_q frozen; hit_q<=0; expired_o unchanged.
- Advance condition: adv = !clear_i && !hold_i && en_i && !sat.
- On adv, pre_q increments. When pre_q==PRESCALE-1 it wraps to 0 and count_q increments by 1. With PRESCALE=1 the prescaler is absent and count_q increments on every adv.
- Latency: after clear release, count_q reaches n after exactly n*PRESCALE edges with adv true. expired_o[k] rises on the edge after which count_q==THRESH[k].
- hit_o[k] is registered: set on the edge where count_q transitions to THRESH[k], high for exactly that one cycle, then 0. hit_o[k] and the rising edge of expired_o[k] are coincident.
- Saturation: once count_q==THRESH[NUM_THRESH-1], the counter and prescaler stop; count_q never wraps. expired_o stays all-ones and sat_o stays 1 until clear_i or reset.
- en_i low mid-prescale: pre_q retains its value (no partial-tick loss).
- Simultaneous clear_i and a terminal tick: clear wins; no hit pulse.
- Reset asserted mid-count: all state returns to 0 asynchronously. The first edge after release behaves as if clear had just deasserted.
- Elaboration assertions: THRESH strictly ascending, THRESH[0] >= 1, PRESCALE >= 1, CNT_WIDTH wide enough for THRESH[NUM_THRESH-1].

Decomposition:
- morse_decoder_pkg gains:
  - NUM_TIMER_THRESH_C = 4.
  - typedef enum timer_idx_e {TIDX_DASH, TIDX_ILLEGAL, TIDX_CHAR, TIDX_WORD}, ordered ascending by tick count.
  - TIMER_THRESH_C built from the existing DASH/ILLEGAL_SYMBOL/CHAR/WORD _TICK_COUNT_C constants.
- Consumers index expired_o/hit_o by timer_idx_e.
- One sub-module: tick_prescaler (PRESCALE parameter). Inputs clk, resetn, clear_i, adv_i; output tick_o. Generates the counter increment strobe and is bypassed when PRESCALE=1.

Test Plan:
All cases use THRESH={3,5,8,12}, PRESCALE=2, en_i=1 unless noted.
- Basic: clear_i=1 then 0 → count_o=1 after edge 2, count_o=3 after edge 6. hit_o=0001 for one cycle and expired_o=0001 after edge 6. expired_o=1111 and sat_o=1 after edge 24.
- Saturation: keep running 50 more cycles → count_o stays 12, hit_o stays 0000, expired_o stays 1111.
- Hold: hold_i=1 for 10 cycles at count_o=4 → count_o stays 4 and expired_o stays 0001. Release → count_o=5 and hit_o=0010 after 2 more edges.
- Restart: clear_i pulsed one cycle at count_o=7 → count_o=0 and expired_o=0000 next cycle. Recount reaches 3 after 6 more edges.
- Enable gating: en_i toggled 1,0,1,0,... → count_o=1 after 4 edges (pre_q retained while en_i low).
- Async reset at count_o=10 → all outputs 0 before the next clk edge. After release, count_o=1 after 2 edges. PRESCALE=1 variant: count_o=3 and hit_o[0] after 3 edges.

Source files
------------

// File: rtl/morse_decoder_pkg.sv
// Shared morse_decoder constants, including the interval thresholds served by
// the single multi_threshold_timer instance.
package morse_decoder_pkg;

    localparam int DASH_TICK_COUNT_C           = 3;
    localparam int ILLEGAL_SYMBOL_TICK_COUNT_C = 5;
    localparam int CHAR_TICK_COUNT_C           = 8;
    localparam int WORD_TICK_COUNT_C           = 12;

    localparam int NUM_TIMER_THRESH_C = 4;
    localparam int TIMER_CNT_W_C      = $clog2(WORD_TICK_COUNT_C + 1);

    // Bit positions of expired_o / hit_o, ascending by tick count.
    typedef enum logic [1:0] {
        TIDX_DASH,
        TIDX_ILLEGAL,
        TIDX_CHAR,
        TIDX_WORD
    } timer_idx_e;

    typedef logic [TIMER_CNT_W_C-1:0] tick_cnt_t;

    localparam tick_cnt_t [NUM_TIMER_THRESH_C-1:0] TIMER_THRESH_C = {
        tick_cnt_t'(WORD_TICK_COUNT_C),
        tick_cnt_t'(CHAR_TICK_COUNT_C),
        tick_cnt_t'(ILLEGAL_SYMBOL_TICK_COUNT_C),
        tick_cnt_t'(DASH_TICK_COUNT_C)
    };

endpackage

// File: rtl/multi_threshold_timer_prescaler.sv
// Divides advance cycles by PRESCALE into counter tick strobes; pure
// pass-through when PRESCALE is 1.
module tick_prescaler #(
    parameter int PRESCALE = 1
) (
    input  logic clk,
    input  logic resetn,
    input  logic clear_i,
    input  logic adv_i,
    output logic tick_o
);

    if (PRESCALE <= 1) begin : g_bypass
        logic unused_ctrl;
        assign unused_ctrl = ^{clk, resetn, clear_i};
        assign tick_o      = adv_i;
    end else begin : g_div
        localparam int PRE_W = $clog2(PRESCALE);
        localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE - 1);

        logic [PRE_W-1:0] pre_q;
        logic             wrap;

        assign wrap = (pre_q == PRE_LAST);

        // pre_q only moves on adv_i, so a dropped enable keeps partial progress.
        always_ff @(posedge clk or negedge resetn) begin
            if (!resetn) begin
                pre_q <= '0;
            end else if (clear_i) begin
                pre_q <= '0;
            end else if (adv_i) begin
                pre_q <= wrap ? '0 : pre_q + PRE_W'(1);
            end
        end

        assign tick_o = adv_i && wrap;
    end

endmodule

// File: rtl/multi_threshold_timer.sv
// One shared tick counter with NUM_THRESH ascending compare points, each giving
// an expired level and a registered one-cycle hit pulse; saturates at the last.
module multi_threshold_timer
    import morse_decoder_pkg::*;
#(
    parameter int                         NUM_THRESH = NUM_TIMER_THRESH_C,
    parameter tick_cnt_t [NUM_THRESH-1:0] THRESH     = TIMER_THRESH_C,
    parameter int                         PRESCALE   = 1,
    parameter int                         CNT_WIDTH  = $clog2(int'(THRESH[NUM_THRESH-1]) + 1)
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  clear_i,
    input  logic                  hold_i,
    input  logic                  en_i,
    output logic [CNT_WIDTH-1:0]  count_o,
    output logic [NUM_THRESH-1:0] expired_o,
    output logic [NUM_THRESH-1:0] hit_o,
    output logic                  sat_o
);

    function automatic bit thresh_ascending();
        bit ok;
        ok = (THRESH[0] != '0);
        for (int k = 1; k < NUM_THRESH; k++) begin
            if (THRESH[k] <= THRESH[k-1]) ok = 1'b0;
        end
        return ok;
    endfunction

    localparam bit THRESH_OK = thresh_ascending();
    localparam int LAST_T    = int'(THRESH[NUM_THRESH-1]);

    if (!THRESH_OK) begin : g_chk_thresh
        $error("multi_threshold_timer: THRESH must be strictly ascending and start at >= 1");
    end
    if (PRESCALE < 1) begin : g_chk_prescale
        $error("multi_threshold_timer: PRESCALE must be >= 1");
    end
    if (CNT_WIDTH < $clog2(LAST_T + 1)) begin : g_chk_width
        $error("multi_threshold_timer: CNT_WIDTH too narrow for largest threshold");
    end

    localparam logic [CNT_WIDTH-1:0] SAT_VAL = CNT_WIDTH'(LAST_T);

    logic [CNT_WIDTH-1:0]  count_q;
    logic [CNT_WIDTH-1:0]  count_nxt;
    logic [NUM_THRESH-1:0] hit_q;
    logic [NUM_THRESH-1:0] hit_nxt;
    logic                  sat;
    logic                  adv;
    logic                  tick;

    assign sat       = (count_q == SAT_VAL);
    assign adv       = !clear_i && !hold_i && en_i && !sat;
    assign count_nxt = count_q + CNT_WIDTH'(1);

    tick_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .clk     (clk),
        .resetn  (resetn),
        .clear_i (clear_i),
        .adv_i   (adv),
        .tick_o  (tick)
    );

    for (genvar k = 0; k < NUM_THRESH; k++) begin : g_cmp
        localparam logic [CNT_WIDTH-1:0] T_K = CNT_WIDTH'(THRESH[k]);
        assign expired_o[k] = (count_q >= T_K);
        assign hit_nxt[k]   = tick && (count_nxt == T_K);
    end

    // hit_q is rebuilt every non-clear edge, so hold and idle cycles drop it to 0.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            count_q <= '0;
            hit_q   <= '0;
        end else if (clear_i) begin
            count_q <= '0;
            hit_q   <= '0;
        end else begin
            if (tick) count_q <= count_nxt;
            hit_q <= hit_nxt;
        end
    end

    assign count_o = count_q;
    assign hit_o   = hit_q;
    assign sat_o   = sat;

endmodule

// File: tb/tb_multi_threshold_timer.sv
// Directed bench for multi_threshold_timer with THRESH={3,5,8,12}: a PRESCALE=2
// instance driven from a vector table and a PRESCALE=1 instance for the variant.
module tb_multi_threshold_timer;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    logic       clr2 = 1'b1, hld2 = 1'b0, en2 = 1'b0;
    logic       clr1 = 1'b1, hld1 = 1'b0, en1 = 1'b0;
    logic [3:0] cnt2, exp2, hit2, cnt1, exp1, hit1;
    logic       sat2, sat1;

    multi_threshold_timer #(.PRESCALE(2)) u_p2 (
        .clk(clk), .resetn(resetn), .clear_i(clr2), .hold_i(hld2), .en_i(en2),
        .count_o(cnt2), .expired_o(exp2), .hit_o(hit2), .sat_o(sat2)
    );

    multi_threshold_timer #(.PRESCALE(1)) u_p1 (
        .clk(clk), .resetn(resetn), .clear_i(clr1), .hold_i(hld1), .en_i(en1),
        .count_o(cnt1), .expired_o(exp1), .hit_o(hit1), .sat_o(sat1)
    );

    typedef struct {
        logic       clr;
        logic       hld;
        logic       en;
        int         n;
        logic [3:0] cnt;
        logic [3:0] expd;
        logic [3:0] hit;
        logic       sat;
    } vec_t;

    vec_t vecs[$];
    int   checks = 0;
    int   errors = 0;

    task automatic add(input logic c, input logic h, input logic e, input int n,
                       input logic [3:0] cnt, input logic [3:0] expd,
                       input logic [3:0] hit, input logic sat);
        vec_t v;
        v.clr = c; v.hld = h; v.en = e; v.n = n;
        v.cnt = cnt; v.expd = expd; v.hit = hit; v.sat = sat;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    task automatic chk_p2(input string tag, input logic [3:0] cnt, input logic [3:0] expd,
                          input logic [3:0] hit, input logic sat);
        chk({tag, ".count"},   32'(cnt2), 32'(cnt));
        chk({tag, ".expired"}, 32'(exp2), 32'(expd));
        chk({tag, ".hit"},     32'(hit2), 32'(hit));
        chk({tag, ".sat"},     32'(sat2), 32'(sat));
    endtask

    task automatic chk_p1(input string tag, input logic [3:0] cnt, input logic [3:0] expd,
                          input logic [3:0] hit, input logic sat);
        chk({tag, ".count"},   32'(cnt1), 32'(cnt));
        chk({tag, ".expired"}, 32'(exp1), 32'(expd));
        chk({tag, ".hit"},     32'(hit1), 32'(hit));
        chk({tag, ".sat"},     32'(sat1), 32'(sat));
    endtask

    task automatic run(input int n);
        repeat (n) @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        //   clr hld en  n    count   expired  hit      sat
        add(1, 0, 0,  1,  4'd0,  4'b0000, 4'b0000, 0);  // clear
        add(0, 0, 1,  2,  4'd1,  4'b0000, 4'b0000, 0);  // first tick after 2 edges
        add(0, 0, 1,  4,  4'd3,  4'b0000 | 4'b0001, 4'b0001, 0);
        add(0, 0, 1,  1,  4'd3,  4'b0001, 4'b0000, 0);  // pulse lasts one cycle
        add(0, 0, 1,  1,  4'd4,  4'b0001, 4'b0000, 0);
        add(0, 1, 1, 10,  4'd4,  4'b0001, 4'b0000, 0);  // hold
        add(0, 0, 1,  2,  4'd5,  4'b0011, 4'b0010, 0);
        add(0, 0, 1,  1,  4'd5,  4'b0011, 4'b0000, 0);
        add(0, 0, 1,  3,  4'd7,  4'b0011, 4'b0000, 0);
        add(1, 0, 1,  1,  4'd0,  4'b0000, 4'b0000, 0);  // restart at 7
        add(0, 0, 1,  6,  4'd3,  4'b0001, 4'b0001, 0);
        add(1, 0, 0,  1,  4'd0,  4'b0000, 4'b0000, 0);
        add(0, 0, 1,  1,  4'd0,  4'b0000, 4'b0000, 0);  // enable gating
        add(0, 0, 0,  1,  4'd0,  4'b0000, 4'b0000, 0);
        add(0, 0, 1,  1,  4'd1,  4'b0000, 4'b0000, 0);
        add(0, 0, 0,  1,  4'd1,  4'b0000, 4'b0000, 0);
        add(0, 0, 1, 13,  4'd7,  4'b0011, 4'b0000, 0);
        add(0, 0, 1,  1,  4'd8,  4'b0111, 4'b0100, 0);
        add(0, 0, 1,  7,  4'd11, 4'b0111, 4'b0000, 0);
        add(0, 0, 1,  1,  4'd12, 4'b1111, 4'b1000, 1);  // saturation reached
        add(0, 0, 1, 50,  4'd12, 4'b1111, 4'b0000, 1);  // no wrap
        add(0, 1, 0,  1,  4'd12, 4'b1111, 4'b0000, 1);
        add(1, 0, 1,  1,  4'd0,  4'b0000, 4'b0000, 0);
        add(0, 0, 1,  5,  4'd2,  4'b0000, 4'b0000, 0);  // prescaler at terminal
        add(1, 0, 1,  1,  4'd0,  4'b0000, 4'b0000, 0);  // clear beats tick
        add(0, 0, 1,  1,  4'd0,  4'b0000, 4'b0000, 0);

        // Reset state while resetn is held low.
        run(2);
        chk_p2("reset_p2", 4'd0, 4'b0000, 4'b0000, 0);
        chk_p1("reset_p1", 4'd0, 4'b0000, 4'b0000, 0);
        resetn = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            clr2 = vecs[i].clr;
            hld2 = vecs[i].hld;
            en2  = vecs[i].en;
            run(vecs[i].n);
            chk_p2($sformatf("vec%0d", i), vecs[i].cnt, vecs[i].expd, vecs[i].hit, vecs[i].sat);
        end

        // Count 0 with pre at 1: 19 more edges make 20 advances, i.e. count 10.
        clr2 = 1'b0; hld2 = 1'b0; en2 = 1'b1;
        run(19);
        chk_p2("pre_async", 4'd10, 4'b0111, 4'b0000, 0);

        // Asynchronous reset between edges.
        resetn = 1'b0;
        #1;
        chk_p2("async_p2", 4'd0, 4'b0000, 4'b0000, 0);
        chk_p1("async_p1", 4'd0, 4'b0000, 4'b0000, 0);
        #1;
        resetn = 1'b1;
        clr1 = 1'b0; en1 = 1'b1;
        run(2);
        chk_p2("post_reset_p2", 4'd1, 4'b0000, 4'b0000, 0);
        chk_p1("post_reset_p1", 4'd2, 4'b0000, 4'b0000, 0);
        run(1);
        chk_p1("p1_dash", 4'd3, 4'b0001, 4'b0001, 0);
        chk_p2("p2_mid", 4'd1, 4'b0000, 4'b0000, 0);
        run(1);
        chk_p1("p1_after_dash", 4'd4, 4'b0001, 4'b0000, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
